demux_sched: RTL

Round-robin distributor that sequences a 1-to-4 demultiplexer. It accepts a single valid/ready input stream and steers each word to one of four output lanes. Each lane has its own holding register and valid/ready handshake. It sits in front of the demux datapath and owns the select lines (`sel`), so that downstream consumers of different speeds can share one producer.

---
 rtl/demux_sched_pkg.sv | 18 +
 rtl/demux_sched_lane.sv | 37 +++
 rtl/demux_sched.sv | 58 +++++
 3 files changed

// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants and rotating-priority lane search for demux_sched
package demux_sched_pkg;

   localparam int LANES = 4;
   localparam int SEL_W = 2;

   // First free lane starting at ptr and wrapping; falls back to ptr when none is free.
   // Scans from the farthest offset down so the nearest free lane wins.
   function automatic logic [SEL_W-1:0] next_free(input logic [SEL_W-1:0] ptr, input logic [LANES-1:0] free);
      logic [SEL_W-1:0] idx;
      next_free = ptr;
      for (int i = LANES - 1; i >= 0; i--) begin
         idx = ptr + SEL_W'(i);
         if (free[idx]) next_free = idx;
      end
   endfunction

endpackage

// File: rtl/demux_sched_lane.sv
// demux_sched_lane: one output lane holding register with valid flag, load/drain and async reset
module demux_sched_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             ready,
   input  logic [WIDTH-1:0] din,
   output logic             vld,
   output logic [WIDTH-1:0] dout
);

   logic             vld_d, vld_q;
   logic [WIDTH-1:0] data_d, data_q;

   // a load wins over a same-cycle drain; a plain drain keeps the last data
   always_comb begin
      vld_d  = load | (vld_q & ~ready);
      data_d = load ? din : data_q;
   end

   // lane state register, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign vld  = vld_q;
   assign dout = data_q;

endmodule

// File: rtl/demux_sched.sv
// demux_sched: round-robin 1-to-4 stream distributor; define DEMUX_SCHED_SKIP_BUSY_EN to skip stalled lanes
module demux_sched
   import demux_sched_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [SEL_W-1:0]       sel,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ready
);

   logic [SEL_W-1:0] ptr_d, ptr_q, target;
   logic [LANES-1:0] vld, free, load;
   logic             accept;

   // target lane selection, input handshake and pointer advance
   always_comb begin
      free = ~vld | out_ready;
`ifdef DEMUX_SCHED_SKIP_BUSY_EN
      target   = next_free(ptr_q, free);
      in_ready = |free;
`else
      target   = ptr_q;
      in_ready = free[ptr_q];
`endif
      accept = in_valid && in_ready;
      ptr_d  = accept ? target + SEL_W'(1) : ptr_q;
      for (int i = 0; i < LANES; i++) load[i] = accept && (target == SEL_W'(i));
   end

   // round-robin pointer, moves only on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign sel       = ptr_q;
   assign out_valid = vld;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      demux_sched_lane #(.WIDTH(WIDTH)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .load (load[k]),
         .ready(out_ready[k]),
         .din  (in_data),
         .vld  (vld[k]),
         .dout (out_data[k*WIDTH +: WIDTH])
      );
   end

endmodule
